// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair; one operand bit per clock,
// with sign fix-up in a final cycle, MTHI/MTLO writes, cancel and divide-by-zero flag.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO write here
// RUN    | one shift-add / shift-subtract step per edge
// FIX    | sign correction and HI/LO write-back
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Operand magnitudes; negating the most-negative value wraps to 2^(WIDTH-1).
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = (op == 3'd0) || (op == 3'd2);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? neg_w(a) : a;
    assign b_mag     = b_neg ? neg_w(b) : b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]  mul_sum;
    logic [W2-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? ma_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_sub;
    logic [W2-1:0]    div_next;
    assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = rem_sh >= {1'b0, mb_q};
    assign rem_sub  = rem_sh[WIDTH-1:0] - mb_q;
    assign div_next = div_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    logic             neg_res;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, a_raw;
    assign neg_res  = sa_q ^ sb_q;
    assign prod_fix = neg_res ? (~acc_q + W2'(1)) : acc_q;
    assign quo_fix  = neg_res ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix  = sa_q ? neg_w(acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
    assign a_raw    = sa_q ? neg_w(ma_q) : ma_q;

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'd4: hi_d = a;
                        3'd5: lo_d = a;
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            is_div_d = op[1];
                            sa_d     = a_neg;
                            sb_d     = b_neg;
                            ma_d     = a_mag;
                            mb_d     = b_mag;
                            cnt_d    = CW'(WIDTH - 1);
                            acc_d    = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                            if (op[1] && (b == '0)) begin
                                dz_d    = 1'b1;
                                state_d = S_FIX;
                            end else begin
                                dz_d    = 1'b0;
                                state_d = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    done_d     = 1'b1;
                    div_zero_d = dz_q;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (dz_q) begin
                        hi_d = a_raw;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ma_q       <= '0;
            mb_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32 and WIDTH=8: arithmetic reference model with a
// per-cycle compare, directed scenarios with literal results, then random traffic.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        st  [2];
    logic [2:0]  opv [2];
    logic [31:0] av  [2];
    logic [31:0] bv  [2];
    logic        cn  [2];

    logic        busy0, done0, dz0, busy1, done1, dz1;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi1, lo1;

    muldiv_unit #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset(reset), .start(st[0]), .op(opv[0]), .a(av[0]), .b(bv[0]),
        .cancel(cn[0]), .busy(busy0), .done(done0), .div_zero(dz0), .hi(hi0), .lo(lo0)
    );

    muldiv_unit #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .start(st[1]), .op(opv[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
        .cancel(cn[1]), .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] maskw(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] d_hi(input int i);
        return (i == 0) ? hi0 : {24'd0, hi1};
    endfunction
    function automatic logic [31:0] d_lo(input int i);
        return (i == 0) ? lo0 : {24'd0, lo1};
    endfunction
    function automatic logic d_busy(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction
    function automatic logic d_done(input int i);
        return (i == 0) ? done0 : done1;
    endfunction
    function automatic logic d_dz(input int i);
        return (i == 0) ? dz0 : dz1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
        end
    endtask

    // Arithmetic reference: plain 64-bit integer multiply/divide on the w-bit operands.
    function automatic void ref_op(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl,
                                   output bit rdz);
        longint unsigned m, au, bu, p;
        longint          sa, sb;
        logic [31:0]     m32;
        m   = (64'd1 << w) - 64'd1;
        m32 = m[31:0];
        au  = {32'd0, a} & m;
        bu  = {32'd0, b} & m;
        sa  = longint'(au);
        sb  = longint'(bu);
        if (au[w-1]) sa = sa - longint'(64'd1 << w);
        if (bu[w-1]) sb = sb - longint'(64'd1 << w);
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        p   = '0;
        case (op)
            3'd0: p = 64'(sa * sb);
            3'd1: p = au * bu;
            3'd2, 3'd3: begin
                if (bu == 0) begin
                    rdz = 1'b1;
                    rh  = a & m32;
                    rl  = m32;
                end else if (op == 3'd2) begin
                    rl = 32'(sa / sb) & m32;
                    rh = 32'(sa % sb) & m32;
                end else begin
                    rl = 32'(au / bu);
                    rh = 32'(au % bu);
                end
            end
            default: ;
        endcase
        if (op <= 3'd1) begin
            rh = 32'((p >> w) & m);
            rl = 32'(p & m);
        end
    endfunction

    // Transaction-level model: result computed at start, delivered after the op's latency.
    logic [31:0] m_hi [2], m_lo [2], p_hi [2], p_lo [2];
    bit          m_busy [2], m_done [2], m_dz [2], p_dz [2];
    int          m_left [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_hi[i] = '0; m_lo[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
                m_dz[i] = 1'b0; m_left[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 1'b0;
                m_dz[i]   = 1'b0;
                if (m_busy[i]) begin
                    if (cn[i]) begin
                        m_busy[i] = 1'b0;
                    end else if (m_left[i] == 1) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_dz[i]   = p_dz[i];
                        m_hi[i]   = p_hi[i];
                        m_lo[i]   = p_lo[i];
                    end else begin
                        m_left[i]--;
                    end
                end else if (st[i]) begin
                    if (opv[i] == 3'd4) begin
                        m_hi[i] = av[i] & maskw(i);
                    end else if (opv[i] == 3'd5) begin
                        m_lo[i] = av[i] & maskw(i);
                    end else if (opv[i] <= 3'd3) begin
                        ref_op(wid(i), opv[i], av[i], bv[i], p_hi[i], p_lo[i], p_dz[i]);
                        m_busy[i] = 1'b1;
                        m_left[i] = (opv[i][1] && ((bv[i] & maskw(i)) == 32'd0)) ? 1 : wid(i) + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("w%0d_busy", wid(i)), 32'(d_busy(i)), 32'(m_busy[i]));
                chk($sformatf("w%0d_done", wid(i)), 32'(d_done(i)), 32'(m_done[i]));
                chk($sformatf("w%0d_div_zero", wid(i)), 32'(d_dz(i)), 32'(m_dz[i]));
                chk($sformatf("w%0d_hi", wid(i)), d_hi(i), m_hi[i]);
                chk($sformatf("w%0d_lo", wid(i)), d_lo(i), m_lo[i]);
            end
        end
    end

    task automatic issue(input int i, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        st[i] = 1'b1; opv[i] = o; av[i] = x; bv[i] = y;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int n);
        n = 0;
        while (!d_done(i) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("w%0d_done_seen", wid(i)), 32'(d_done(i)), 32'd1);
    endtask

    task automatic run(input int i, input string nm, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input bit edz);
        int n;
        issue(i, o, x, y);
        wait_done(i, n);
        chk({nm, "_latency"}, 32'(n), (edz ? 32'd1 : 32'(wid(i) + 1)));
        chk({nm, "_hi"}, d_hi(i), eh);
        chk({nm, "_lo"}, d_lo(i), el);
        chk({nm, "_div_zero"}, 32'(d_dz(i)), 32'(edz));
    endtask

    function automatic logic [31:0] rnd_val(input int i);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return maskw(i);
            3:       return 32'd1 << (wid(i) - 1);
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom & maskw(i);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; opv[i] = 3'd0; av[i] = '0; bv[i] = '0; cn[i] = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_hi", hi0, 32'd0);
        chk("rst_lo", lo0, 32'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        run(0, "mult_neg1x3", 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(0, "multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run(0, "div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(0, "divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run(0, "div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run(0, "divu_by0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        st[0] = 1'b1; opv[0] = 3'd4; av[0] = 32'h1234;
        @(negedge clk);
        opv[0] = 3'd5; av[0] = 32'h5678;
        @(negedge clk);
        st[0] = 1'b0;
        chk("mt_hi", hi0, 32'h1234);
        chk("mt_lo", lo0, 32'h5678);
        chk("mt_busy", 32'(busy0), 32'd0);

        // second start while busy must be ignored
        begin
            int n;
            issue(0, 3'd0, 32'd5, 32'd6);
            repeat (3) @(negedge clk);
            st[0] = 1'b1; opv[0] = 3'd0; av[0] = 32'd100; bv[0] = 32'd100;
            @(negedge clk);
            st[0] = 1'b0;
            wait_done(0, n);
            chk("busy_start_lo", lo0, 32'd30);
            chk("busy_start_hi", hi0, 32'd0);
        end

        // cancel mid-run
        issue(0, 3'd0, 32'd9, 32'd9);
        repeat (8) @(negedge clk);
        cn[0] = 1'b1;
        @(negedge clk);
        cn[0] = 1'b0;
        chk("cancel_busy", 32'(busy0), 32'd0);
        repeat (40) @(negedge clk);
        chk("cancel_hi", hi0, 32'd0);
        chk("cancel_lo", lo0, 32'd30);
        run(0, "mult_6x7", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // cancel on the fix-up edge wins
        issue(0, 3'd0, 32'd3, 32'd3);
        repeat (32) @(negedge clk);
        cn[0] = 1'b1;
        @(negedge clk);
        cn[0] = 1'b0;
        chk("cancel_fix_done", 32'(done0), 32'd0);
        chk("cancel_fix_busy", 32'(busy0), 32'd0);
        chk("cancel_fix_lo", lo0, 32'd42);

        // asynchronous reset in the middle of a divide
        issue(0, 3'd2, 32'h1000, 32'd3);
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy0), 32'd0);
        chk("async_rst_done", 32'(done0), 32'd0);
        chk("async_rst_hi", hi0, 32'd0);
        chk("async_rst_lo", lo0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run(0, "divu_9_3", 3'd3, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        run(1, "w8_mult_ff_3", 3'd0, 32'hFF, 32'd3, 32'hFF, 32'hFD, 1'b0);
        run(1, "w8_multu_ff", 3'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
        run(1, "w8_div_m7_2", 3'd2, 32'hF9, 32'd2, 32'hFF, 32'hFD, 1'b0);
        run(1, "w8_divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run(1, "w8_div_min_m1", 3'd2, 32'h80, 32'hFF, 32'd0, 32'h80, 1'b0);
        run(1, "w8_divu_by0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFF, 1'b1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                st[i]  = ($urandom_range(0, 3) == 0);
                opv[i] = 3'($urandom_range(0, 7));
                av[i]  = rnd_val(i);
                bv[i]  = rnd_val(i);
                cn[i]  = ($urandom_range(0, 59) == 0);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; cn[i] = 1'b0;
        end
        repeat (40) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
